// File: rtl/alu_ctrl_pkg.sv
// Shared opcode map, ALU operation codes and control-strobe bundle for alu_ctrl_exec.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LD  = 4'h4;
    localparam logic [3:0] OP_ST  = 4'h5;
    localparam logic [3:0] OP_BEQ = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_NOP = 4'hC;

    localparam logic [3:0] ALU_OP_NONE = 4'hF;

    // branch here means "is a BEQ"; the top qualifies it with operand equality
    typedef struct packed {
        logic memRead;
        logic memWrite;
        logic regWrite;
        logic branch;
        logic jump;
    } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational opcode decoder: control strobes, alu_op and the flag-update class.
// Shift opcodes decode only when ALU_SHIFT_EN is defined; otherwise they fall to NOP.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic [3:0] aluOp_o,
    output logic       aluClass_o
);

    always_comb begin
        ctrl_o     = '0;
        aluOp_o    = ALU_OP_NONE;
        aluClass_o = 1'b0;
        case (opcode_i)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_NOT: begin
                ctrl_o.regWrite = 1'b1;
                aluOp_o         = opcode_i;
                aluClass_o      = 1'b1;
            end
`ifdef ALU_SHIFT_EN
            OP_SHL, OP_SHR: begin
                ctrl_o.regWrite = 1'b1;
                aluOp_o         = opcode_i;
                aluClass_o      = 1'b1;
            end
`endif
            OP_BEQ: begin
                ctrl_o.branch = 1'b1;
                aluOp_o       = opcode_i;
                aluClass_o    = 1'b1;
            end
            OP_LD: begin
                ctrl_o.memRead  = 1'b1;
                ctrl_o.regWrite = 1'b1;
            end
            OP_ST:   ctrl_o.memWrite = 1'b1;
            OP_JMP:  ctrl_o.jump     = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_exec.sv
// Decode-and-execute stage: one-cycle registered ALU result, flags and control strobes.
// Optional SHL/SHR support is enabled by defining ALU_SHIFT_EN.
module alu_ctrl_exec
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic [3:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             branch,
    output logic             jump
);

    ctrl_t            decCtrl;
    logic [3:0]       decAluOp;
    logic             decAluClass;

    logic [WIDTH:0]   sumWide;
    logic [WIDTH:0]   diffWide;
    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             zero_q, negative_q, valid_q;
    logic [3:0]       aluOp_q;
    ctrl_t            ctrl_d, ctrl_q;

    alu_ctrl_decode u_decode (
        .opcode_i   (opcode),
        .ctrl_o     (decCtrl),
        .aluOp_o    (decAluOp),
        .aluClass_o (decAluClass)
    );

    assign sumWide  = {1'b0, a} + {1'b0, b};
    assign diffWide = {1'b0, a} - {1'b0, b};

    // Bit WIDTH of the widened difference is the unsigned borrow (a < b)
    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        case (opcode)
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_XOR: result_d = a ^ b;
            OP_NOT: result_d = ~a;
            OP_ADD: begin
                result_d = sumWide[WIDTH-1:0];
                carry_d  = sumWide[WIDTH];
            end
            OP_SUB, OP_BEQ: begin
                result_d = diffWide[WIDTH-1:0];
                carry_d  = diffWide[WIDTH];
            end
            OP_LD, OP_JMP: result_d = a;
            OP_ST:         result_d = b;
`ifdef ALU_SHIFT_EN
            OP_SHL: begin
                result_d = {a[WIDTH-2:0], 1'b0};
                carry_d  = a[WIDTH-1];
            end
            OP_SHR: begin
                result_d = {1'b0, a[WIDTH-1:1]};
                carry_d  = a[0];
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        ctrl_d        = decCtrl;
        ctrl_d.branch = decCtrl.branch && (a == b);
    end

    // Idle cycles clear strobes but keep result, flags and alu_op for writeback
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            negative_q <= 1'b0;
            aluOp_q    <= '0;
            ctrl_q     <= '0;
        end else if (in_valid) begin
            valid_q  <= 1'b1;
            result_q <= result_d;
            aluOp_q  <= decAluOp;
            ctrl_q   <= ctrl_d;
            if (decAluClass) begin
                zero_q     <= (result_d == '0);
                carry_q    <= carry_d;
                negative_q <= result_d[WIDTH-1];
            end
        end else begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign negative  = negative_q;
    assign alu_op    = aluOp_q;
    assign mem_read  = ctrl_q.memRead;
    assign mem_write = ctrl_q.memWrite;
    assign reg_write = ctrl_q.regWrite;
    assign branch    = ctrl_q.branch;
    assign jump      = ctrl_q.jump;

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Self-checking bench for alu_ctrl_exec: directed plan cases plus random ops vs. an arithmetic model.
// Honours ALU_SHIFT_EN the same way as the design.
module tb_alu_ctrl_exec;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [3:0]   opcode;
    logic [W-1:0] a, b;
    logic         out_valid, zero, carry, negative;
    logic [W-1:0] result;
    logic [3:0]   alu_op;
    logic         mem_read, mem_write, reg_write, branch, jump;

    int total = 0;
    int bad   = 0;

    // Reference state: what the outputs should hold after the last edge
    int expValid, expResult, expZero, expCarry, expNeg, expAluOp;
    int expMr, expMw, expRw, expBr, expJp;

`ifdef ALU_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    alu_ctrl_exec #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .negative  (negative),
        .alu_op    (alu_op),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .branch    (branch),
        .jump      (jump)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        expValid = 0; expResult = 0; expZero = 0; expCarry = 0; expNeg = 0; expAluOp = 0;
        expMr = 0; expMw = 0; expRw = 0; expBr = 0; expJp = 0;
    endtask

    // Plain-arithmetic model of one clock edge
    task automatic modelStep(input int v, input int op, input int x, input int y);
        int r, c;
        bit flagOp;
        if (v == 0) begin
            expValid = 0;
            expMr = 0; expMw = 0; expRw = 0; expBr = 0; expJp = 0;
            return;
        end
        expValid = 1;
        expMr = 0; expMw = 0; expRw = 0; expBr = 0; expJp = 0;
        r = 0; c = 0; flagOp = 0;
        case (op)
            0:  begin r = x & y;               flagOp = 1; expRw = 1; end
            1:  begin r = x | y;               flagOp = 1; expRw = 1; end
            2:  begin r = (x + y) % 256; c = (x + y > 255) ? 1 : 0; flagOp = 1; expRw = 1; end
            3:  begin r = (x - y + 256) % 256; c = (x < y) ? 1 : 0; flagOp = 1; expRw = 1; end
            4:  begin r = x; expMr = 1; expRw = 1; end
            5:  begin r = y; expMw = 1; end
            6:  begin r = (x - y + 256) % 256; c = (x < y) ? 1 : 0; flagOp = 1; expBr = (x == y) ? 1 : 0; end
            7:  begin r = x; expJp = 1; end
            8:  begin r = x ^ y;               flagOp = 1; expRw = 1; end
            9:  begin r = 255 - x;             flagOp = 1; expRw = 1; end
            10: if (SHIFT_EN) begin r = (x * 2) % 256; c = x / 128; flagOp = 1; expRw = 1; end
            11: if (SHIFT_EN) begin r = x / 2;         c = x % 2;   flagOp = 1; expRw = 1; end
            default: r = 0;
        endcase
        expResult = r;
        expAluOp  = flagOp ? op : 15;
        if (flagOp) begin
            expCarry = c;
            expZero  = (r == 0) ? 1 : 0;
            expNeg   = (r >= 128) ? 1 : 0;
        end
    endtask

    task automatic checkOne(input string tag, input logic [W-1:0] obs, input int expv);
        logic [W-1:0] e;
        e = expv[W-1:0];
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, ".valid"},  {7'd0, out_valid}, expValid);
        checkOne({tag, ".result"}, result, expResult);
        checkOne({tag, ".zero"},   {7'd0, zero}, expZero);
        checkOne({tag, ".carry"},  {7'd0, carry}, expCarry);
        checkOne({tag, ".neg"},    {7'd0, negative}, expNeg);
        checkOne({tag, ".aluop"},  {4'd0, alu_op}, expAluOp);
        checkOne({tag, ".strobes"}, {3'd0, mem_read, mem_write, reg_write, branch, jump},
                 expMr * 16 + expMw * 8 + expRw * 4 + expBr * 2 + expJp);
    endtask

    task automatic applyStimulus(input string tag, input int v, input int op, input int x, input int y);
        @(negedge clk);
        in_valid = v[0];
        opcode   = op[3:0];
        a        = x[W-1:0];
        b        = y[W-1:0];
        @(posedge clk);
        #1;
        modelStep(v, op, x, y);
        checkOutput(tag);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; opcode = '0; a = '0; b = '0;
        modelReset();
        #12;
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b0;

        applyStimulus("add_ovf",  1, 2, 200, 100);
        checkOne("add_ovf.lit", result, 44);
        applyStimulus("add_zero", 1, 2, 0, 0);
        applyStimulus("sub_neg",  1, 3, 5, 7);
        checkOne("sub_neg.lit", result, 254);
        applyStimulus("sub_eq",   1, 3, 7, 7);
        applyStimulus("and",      1, 0, 'hF0, 'h3C);
        applyStimulus("or",       1, 1, 'hF0, 'h3C);
        applyStimulus("xor",      1, 8, 'hF0, 'h3C);
        applyStimulus("not",      1, 9, 'h0F, 'h00);
        applyStimulus("ld",       1, 4, 9, 0);
        applyStimulus("st",       1, 5, 0, 3);
        applyStimulus("beq_eq",   1, 6, 4, 4);
        applyStimulus("beq_ne",   1, 6, 4, 5);
        applyStimulus("jmp",      1, 7, 'h33, 0);
        applyStimulus("add_pre",  1, 2, 1, 1);
        applyStimulus("shl",      1, 10, 'h81, 0);
        applyStimulus("shr",      1, 11, 'h81, 0);
        applyStimulus("nop",      1, 12, 'h55, 'h66);
        applyStimulus("idle",     0, 2, 'h11, 'h22);
        applyStimulus("idle2",    0, 4, 'h11, 'h22);

        // Mid-stream reset must clear between edges
        applyStimulus("pre_rst",  1, 3, 9, 200);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_rst");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("post_rst", 1, 0, 'hAA, 'h0F);

        for (int i = 0; i < 300; i++) begin
            applyStimulus("rand", ($urandom_range(0, 9) < 8) ? 1 : 0,
                          $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
